// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch (IFU) and load/store (LSU).
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_we,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic last_lsu, own_lsu, we_q, lsu_win, acc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  // LSU wins when alone, or on a tie when the IFU was granted last
  always_comb begin
    lsu_win        = lsu_req_valid & (~ifu_req_valid | ~last_lsu);
    ifu_req_ready  = rst_n & (state == IDLE) & ifu_req_valid & ~lsu_win;
    lsu_req_ready  = rst_n & (state == IDLE) & lsu_win;
    acc            = ifu_req_ready | lsu_req_ready;
    state_nx       = state == IDLE ? (acc ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    mem_ce         = state == ACCESS;
    mem_we         = mem_ce & we_q;
    mem_addr       = mem_ce ? addr_q : '0;
    mem_wdata      = mem_ce ? wdata_q : '0;
    mem_wmask      = mem_ce ? wmask_q : '0;
    ifu_resp_valid = (state == RESP) & ~own_lsu;
    lsu_resp_valid = (state == RESP) & own_lsu;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_lsu  <= 1'b1;
      own_lsu   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      if (acc) begin
        last_lsu <= lsu_win;
        own_lsu  <= lsu_win;
        we_q     <= lsu_win & lsu_we;
        addr_q   <= lsu_win ? lsu_addr : ifu_addr;
        wdata_q  <= lsu_win ? lsu_wdata : '0;
        wmask_q  <= lsu_win ? lsu_wmask : '0;
      end
      if (state == ACCESS && !own_lsu) ifu_rdata <= mem_rdata;
      if (state == ACCESS && own_lsu) lsu_rdata <= we_q ? '0 : mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, timing, data return and reset of mem_arbiter.
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr = '0, ifu_rdata;
  logic lsu_req_valid = 1'b0, lsu_req_ready, lsu_we = 1'b0, lsu_resp_valid;
  logic [63:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [7:0] lsu_wmask = '0, mem_wmask;
  logic mem_ce, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = '0;
  int total = 0, bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " ce"}, 64'(mem_ce), 64'd0);
    chk({tag, " we"}, 64'(mem_we), 64'd0);
    chk({tag, " addr"}, mem_addr, 64'd0);
    chk({tag, " ifu_rdy"}, 64'(ifu_req_ready), 64'd0);
    chk({tag, " lsu_rdy"}, 64'(lsu_req_ready), 64'd0);
    chk({tag, " ifu_rv"}, 64'(ifu_resp_valid), 64'd0);
    chk({tag, " lsu_rv"}, 64'(lsu_resp_valid), 64'd0);
  endtask

  initial begin
    // reset state, with a pending fetch that must not see ready
    ifu_req_valid = 1'b1;
    tick(); #1;
    idle_chk("rst");
    chk("rst ifu_rdata", ifu_rdata, 64'd0);
    chk("rst lsu_rdata", lsu_rdata, 64'd0);
    ifu_req_valid = 1'b0;

    // IFU-only read
    tick(); rst_n = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; mem_rdata = 64'h0000_0413_0000_0297;
    #1 chk("rd ifu_rdy", 64'(ifu_req_ready), 64'd1);
    chk("rd lsu_rdy", 64'(lsu_req_ready), 64'd0);
    tick(); ifu_req_valid = 1'b0; #1;
    chk("rd ce", 64'(mem_ce), 64'd1);
    chk("rd we", 64'(mem_we), 64'd0);
    chk("rd addr", mem_addr, 64'h8000_0000);
    chk("rd wmask", 64'(mem_wmask), 64'd0);
    chk("rd ifu_rv early", 64'(ifu_resp_valid), 64'd0);
    tick(); #1;
    chk("rd ifu_rv", 64'(ifu_resp_valid), 64'd1);
    chk("rd lsu_rv", 64'(lsu_resp_valid), 64'd0);
    chk("rd data", ifu_rdata, 64'h0000_0413_0000_0297);
    chk("rd ce off", 64'(mem_ce), 64'd0);
    tick(); mem_rdata = 64'h1111_2222_3333_4444; #1;
    chk("rd ifu_rv end", 64'(ifu_resp_valid), 64'd0);
    chk("rd hold", ifu_rdata, 64'h0000_0413_0000_0297);

    // LSU read then LSU write
    lsu_req_valid = 1'b1; lsu_addr = 64'h100; lsu_we = 1'b0;
    #1 chk("lrd lsu_rdy", 64'(lsu_req_ready), 64'd1);
    tick(); lsu_req_valid = 1'b0; #1;
    chk("lrd addr", mem_addr, 64'h100);
    tick(); #1;
    chk("lrd lsu_rv", 64'(lsu_resp_valid), 64'd1);
    chk("lrd data", lsu_rdata, 64'h1111_2222_3333_4444);
    tick();
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1000; lsu_we = 1'b1;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    #1 chk("wr lsu_rdy", 64'(lsu_req_ready), 64'd1);
    tick(); lsu_req_valid = 1'b0; lsu_we = 1'b0; #1;
    chk("wr ce", 64'(mem_ce), 64'd1);
    chk("wr we", 64'(mem_we), 64'd1);
    chk("wr addr", mem_addr, 64'h8000_1000);
    chk("wr wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("wr wmask", 64'(mem_wmask), 64'h0F);
    tick(); #1;
    chk("wr lsu_rv", 64'(lsu_resp_valid), 64'd1);
    chk("wr ifu_rv", 64'(ifu_resp_valid), 64'd0);
    chk("wr rdata", lsu_rdata, 64'd0);
    chk("wr ifu hold", ifu_rdata, 64'h0000_0413_0000_0297);
    chk("wr mem_we off", 64'(mem_we), 64'd0);

    // both valid continuously from reset: IFU, LSU, IFU, LSU
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 64'h1000;
    lsu_req_valid = 1'b1; lsu_addr = 64'h2000;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0) begin
        chk($sformatf("rr%0d ifu_rdy", c), 64'(ifu_req_ready), 64'((c / 3) % 2 == 0));
        chk($sformatf("rr%0d lsu_rdy", c), 64'(lsu_req_ready), 64'((c / 3) % 2 == 1));
      end else if (c % 3 == 1) begin
        chk($sformatf("rr%0d ce", c), 64'(mem_ce), 64'd1);
        chk($sformatf("rr%0d addr", c), mem_addr, (c / 3) % 2 == 0 ? 64'h1000 : 64'h2000);
        chk($sformatf("rr%0d rdy", c), 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      end else begin
        chk($sformatf("rr%0d ifu_rv", c), 64'(ifu_resp_valid), 64'((c / 3) % 2 == 0));
        chk($sformatf("rr%0d lsu_rv", c), 64'(lsu_resp_valid), 64'((c / 3) % 2 == 1));
      end
      tick();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // LSU arrives while IFU is in ACCESS
    ifu_req_valid = 1'b1; ifu_addr = 64'h3000;
    #1 chk("late ifu_rdy", 64'(ifu_req_ready), 64'd1);
    tick(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_addr = 64'h4000; #1;
    chk("late lsu_rdy acc", 64'(lsu_req_ready), 64'd0);
    chk("late ifu_rv acc", 64'(ifu_resp_valid), 64'd0);
    tick(); #1;
    chk("late lsu_rdy resp", 64'(lsu_req_ready), 64'd0);
    chk("late ifu_rv", 64'(ifu_resp_valid), 64'd1);
    tick(); #1;
    chk("late lsu_rdy idle", 64'(lsu_req_ready), 64'd1);
    chk("late ifu_rv off", 64'(ifu_resp_valid), 64'd0);
    tick(); lsu_req_valid = 1'b0; #1;
    chk("late lsu addr", mem_addr, 64'h4000);
    tick(); #1;
    chk("late lsu_rv", 64'(lsu_resp_valid), 64'd1);
    chk("late ifu_rv2", 64'(ifu_resp_valid), 64'd0);

    // reset during ACCESS abandons the transaction
    tick(); ifu_req_valid = 1'b1; ifu_addr = 64'h5000;
    tick(); ifu_req_valid = 1'b0; #1;
    chk("ar ce before", 64'(mem_ce), 64'd1);
    rst_n = 1'b0; #1;
    chk("ar ce", 64'(mem_ce), 64'd0);
    chk("ar ifu_rdata", ifu_rdata, 64'd0);
    chk("ar lsu_rdata", lsu_rdata, 64'd0);
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 idle_chk($sformatf("ar post%0d", c));
      tick();
    end
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_we = 1'b0;
    #1 chk("ar tie ifu_rdy", 64'(ifu_req_ready), 64'd1);
    chk("ar tie lsu_rdy", 64'(lsu_req_ready), 64'd0);
    tick(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick(); #1;
    chk("ar ifu_rv", 64'(ifu_resp_valid), 64'd1);

    // long idle
    tick();
    for (int c = 0; c < 10; c++) begin
      #1 idle_chk($sformatf("idle%0d", c));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
